// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch state encoding and PC arithmetic for the fetch sequencer.
package fetch_unit_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^ADDR_W with no carry out.
  function automatic addr_t pc_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit connections: pc register loop, imem req/ack, decode valid/ready, redirect.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  addr_t  pc_cur;
  addr_t  pc_next;
  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_ack;
  instr_t imem_data;
  logic   instr_valid;
  logic   instr_ready;
  instr_t instr;
  addr_t  instr_pc;
  logic   br_taken;
  addr_t  br_target;

  modport master (
    input  pc_cur, imem_ack, imem_data, instr_ready, br_taken, br_target,
    output pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output pc_cur, imem_ack, imem_data, instr_ready, br_taken, br_target,
    input  pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit_ibuf.sv
// One-entry instruction buffer: load wins over clear, contents hold while valid.
module fetch_ibuf
  import fetch_unit_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  instr_t load_instr,
  input  addr_t  load_pc,
  output logic   valid,
  output instr_t instr,
  output addr_t  instr_pc
);
  logic   valid_reg;
  instr_t instr_reg;
  addr_t  instr_pc_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else if (load) begin
      valid_reg    <= 1'b1;
      instr_reg    <= load_instr;
      instr_pc_reg <= load_pc;
    end else if (clear) begin
      valid_reg    <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign instr    = instr_reg;
  assign instr_pc = instr_pc_reg;
endmodule

// File: rtl/fetch_unit.sv
// Next-PC and fetch sequencer: drives the pc register input, runs the imem
// handshake and presents one buffered instruction at a time to decode.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  fetch_state_e state_reg, state_next;
  addr_t        flush_addr_reg;
  logic         buf_load, buf_clear, buf_valid, fire;
  instr_t       buf_instr;
  addr_t        buf_pc;

  assign fire = buf_valid & bus.instr_ready;

  // pc_cur already holds the redirect target once S_FLUSH is entered, so the
  // outstanding request address has to be kept here until its ack arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_START;
      flush_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_REQ && !bus.imem_ack && bus.br_taken)
        flush_addr_reg <= bus.pc_cur;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.pc_next   = bus.pc_cur;
    bus.imem_req  = 1'b0;
    bus.imem_addr = bus.pc_cur;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    case (state_reg)
      S_START: state_next = S_REQ;
      S_REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack && !bus.br_taken) begin
          buf_load    = 1'b1;
          bus.pc_next = pc_inc(bus.pc_cur);
          state_next  = S_HOLD;
        end else if (!bus.imem_ack && bus.br_taken) begin
          state_next  = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (bus.br_taken || fire) begin
          buf_clear  = 1'b1;
          state_next = S_REQ;
        end
      end
      S_FLUSH: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = flush_addr_reg;
        if (bus.imem_ack)
          state_next = S_REQ;
      end
      default: state_next = S_START;
    endcase
    // A redirect overrides the PC in every state; the buffer/FSM effects are above.
    if (bus.br_taken)
      bus.pc_next = bus.br_target;
  end

  fetch_ibuf u_ibuf (
    .clock      (clock),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (bus.imem_data),
    .load_pc    (bus.pc_cur),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .instr_pc   (buf_pc)
  );

  assign bus.instr_valid = buf_valid;
  assign bus.instr       = buf_instr;
  assign bus.instr_pc    = buf_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an external pc register and a memory model.
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       auto_ack = 1'b0;
  logic       man_ack  = 1'b0;
  logic [7:0] pc_reg;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) pc_reg <= 8'h00;
    else       pc_reg <= bus.pc_next;
  end

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  assign bus.pc_cur    = pc_reg;
  assign bus.imem_ack  = auto_ack ? bus.imem_req : man_ack;
  assign bus.imem_data = mem_word(bus.imem_addr);

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = 8'h00;

    // Reset values
    tick();
    check("rst_req",     bus.imem_req, 0);
    check("rst_valid",   bus.instr_valid, 0);
    check("rst_instr",   bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_pc_next", bus.pc_next, 0);

    // Zero-wait streaming: one instruction every second cycle from 00 upward
    reset = 1'b0;
    auto_ack = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stream_valid", bus.instr_valid, i % 2);
      if (i % 2 == 1) begin
        check("stream_pc",    bus.instr_pc, i / 2);
        check("stream_instr", bus.instr, mem_word(8'(i / 2)));
      end else begin
        check("stream_addr", bus.imem_addr, i / 2);
      end
    end

    // Redirect from S_HOLD to FF, then check the wrap to 00
    auto_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 8'hFF;
    tick();
    bus.br_taken = 1'b0;
    check("wrap_valid", bus.instr_valid, 0);
    check("wrap_addr",  bus.imem_addr, 8'hFF);
    man_ack = 1'b1;
    #1;
    check("wrap_pc_next", bus.pc_next, 8'h00);
    tick();
    man_ack = 1'b0;
    check("wrap_instr_pc", bus.instr_pc, 8'hFF);
    check("wrap_instr",    bus.instr, 16'hA5FF);

    // Decode stalls for 5 cycles in S_HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid",    bus.instr_valid, 1);
      check("hold_instr_pc", bus.instr_pc, 8'hFF);
      check("hold_instr",    bus.instr, 16'hA5FF);
      check("hold_req",      bus.imem_req, 0);
      check("hold_pc_next",  bus.pc_next, 8'h00);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("wrap_next_req",  bus.imem_req, 1);
    check("wrap_next_addr", bus.imem_addr, 8'h00);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("f00_instr_pc", bus.instr_pc, 8'h00);
    tick();
    check("f01_addr", bus.imem_addr, 8'h01);

    // Redirect to 40 while the fetch of 01 is pending; ack 3 cycles later
    bus.br_taken  = 1'b1;
    bus.br_target = 8'h40;
    #1;
    check("flush_pc_next", bus.pc_next, 8'h40);
    tick();
    bus.br_taken = 1'b0;
    check("flush_req1",  bus.imem_req, 1);
    check("flush_addr1", bus.imem_addr, 8'h01);
    tick();
    check("flush_req2",  bus.imem_req, 1);
    check("flush_addr2", bus.imem_addr, 8'h01);
    tick();
    check("flush_addr3", bus.imem_addr, 8'h01);
    man_ack = 1'b1;
    #1;
    check("flush_ack_pc_next", bus.pc_next, 8'h40);
    tick();
    man_ack = 1'b0;
    check("flush_drop_valid", bus.instr_valid, 0);
    check("flush_new_addr",   bus.imem_addr, 8'h40);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("flush_instr_pc", bus.instr_pc, 8'h40);
    check("flush_instr",    bus.instr, mem_word(8'h40));

    // Redirect to 10 with an ack in the same cycle
    tick();
    check("ackbr_addr_before", bus.imem_addr, 8'h41);
    man_ack = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 8'h10;
    #1;
    check("ackbr_pc_next", bus.pc_next, 8'h10);
    tick();
    man_ack = 1'b0;
    bus.br_taken = 1'b0;
    check("ackbr_valid", bus.instr_valid, 0);
    check("ackbr_req",   bus.imem_req, 1);
    check("ackbr_addr",  bus.imem_addr, 8'h10);

    // Redirect in S_HOLD together with a fire
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("holdbr_valid_before", bus.instr_valid, 1);
    check("holdbr_pc_before",    bus.instr_pc, 8'h10);
    bus.br_taken  = 1'b1;
    bus.br_target = 8'h10;
    tick();
    bus.br_taken = 1'b0;
    check("holdbr_valid", bus.instr_valid, 0);
    check("holdbr_addr",  bus.imem_addr, 8'h10);

    // Asynchronous reset in the middle of S_REQ; a late ack must be ignored
    check("midrst_req_before", bus.imem_req, 1);
    reset = 1'b1;
    #1;
    check("midrst_req",   bus.imem_req, 0);
    check("midrst_valid", bus.instr_valid, 0);
    check("midrst_pc",    bus.pc_next, 8'h00);
    man_ack = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("start_req",     bus.imem_req, 0);
    check("start_pc_next", bus.pc_next, 8'h00);
    tick();
    check("restart_req",  bus.imem_req, 1);
    check("restart_addr", bus.imem_addr, 8'h00);
    tick();
    man_ack = 1'b0;
    check("restart_valid",    bus.instr_valid, 1);
    check("restart_instr_pc", bus.instr_pc, 8'h00);
    check("restart_instr",    bus.instr, mem_word(8'h00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
